pwm_ctrl: RTL and testbench
===========================

# pwm_ctrl

Synthesizable digital PWM controller that generates the complementary gate-drive pair for the switched-filter power stage in the emulator, replacing the free-running fixed-duty PWM source. It sequences the stage through idle, soft-start, regulated run and latched fault. Duty and period updates are synchronised to period boundaries. Break-before-make dead time is inserted between the high-side and low-side drives.

## Interface
- CNT_WIDTH, 16: width of the period/duty counters.
- DEAD_TIME, 4: dead-time length in clk cycles; DEAD_TIME ≥ 1.
- SS_STEP, 8: duty increment per period during soft-start.

- clk  in  1  emulator clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- en  in  1  level; run request.
- period  in  CNT_WIDTH  period length minus 1, in clk cycles; sampled at period wrap and on IDLE exit.
- duty  in  CNT_WIDTH  target on-time in cycles.
- duty_wr  in  1  one-cycle strobe; captures duty into the shadow register.
- fault  in  1  level; overcurrent/overvoltage flag.
- fault_clr  in  1  one-cycle strobe; clears the latched fault.
- ctrl  out  1  high-side drive (filter ctrl input).
- ctrl_n  out  1  low-side drive.
- period_start  out  1  one-cycle pulse when cnt==0 in SOFT_START/RUN.
- state  out  2  IDLE=0, SOFT_START=1, RUN=2, FAULT=3.
- duty_act  out  CNT_WIDTH  duty currently applied.

## Operation
- Reset values:
  - ctrl=0, ctrl_n=0, period_start=0, state=IDLE, duty_act=0.
  - cnt=0, shadow duty=0, period_act=0.
- State IDLE:
  - cnt held at 0; both drives 0.
  - en=1 → SOFT_START. On entry: period_act←period, duty_act←0, cnt←0.
- Counter: cnt runs 0..period_act and then wraps to 0. The wrap reloads period_act←period.
- Duty clamp: duty_tgt = min(shadow, period_act+1).
- State SOFT_START, at each wrap:
  - duty_act ← min(duty_act+SS_STEP, duty_tgt).
  - When the new value equals duty_tgt → RUN.
- State RUN: duty_act ← duty_tgt at each wrap only. A mid-period duty_wr never alters the current period.
- Raw PWM: raw = (cnt < duty_act). Computed with CNT_WIDTH+1-bit compare so that duty_act = period_act+1 gives 100 %.
- Dead time, applied on every raw edge:
  - Both drives go to 0 for DEAD_TIME cycles, then the new side asserts.
  - A raw edge during dead time restarts the dead-time count.
  - ctrl & ctrl_n == 1 is illegal in every cycle.
- Fault:
  - fault=1 in any non-IDLE state, or in IDLE, → FAULT. Fault has priority over en.
  - In FAULT: drives 0, cnt held 0, duty_act←0.
  - Exit FAULT → IDLE only on fault_clr=1 with fault=0 in the same cycle; otherwise fault_clr is ignored.
- en=0 in SOFT_START/RUN → IDLE on the next edge; drives 0; duty_act←0.
- Simultaneous events:
  - duty_wr on a wrap cycle: the new value is captured but applied at the following wrap.
  - fault plus en falling: FAULT wins.
- Async reset mid-operation forces all outputs to their reset values without a clock edge.

## Timing
- The state register updates 1 cycle after its cause.
- ctrl/ctrl_n are registered:
  - Each drive asserts DEAD_TIME+1 cycles after the raw edge.
  - Each drive deasserts 1 cycle after the raw edge.
- Pulse widths per period in steady state:
  - ctrl high for max(duty_act−DEAD_TIME, 0) cycles.
  - ctrl_n high for max(period_act+1−duty_act−DEAD_TIME, 0) cycles.
- FAULT/IDLE entry: drives 0 on the same edge that updates state.
- period_start is asserted in the cycle where cnt==0; it is combinational from registered cnt and state.
- Minimum legal period: period ≥ 2·DEAD_TIME+1. Smaller values are clamped to that.

## Structure
- Package pwm_ctrl_pkg holds:
  - the state_t enum (IDLE, SOFT_START, RUN, FAULT, 2-bit);
  - the localparam for the minimum period.
- Sub-module dead_time_gen:
  - inputs raw and active; outputs ctrl and ctrl_n;
  - contains the dead-time counter (width $clog2(DEAD_TIME+1)).
- Top level contains the FSM, counter, shadow/active registers and clamps.

## Test plan
Settings: DEAD_TIME=4, SS_STEP=8, period=99 throughout.
- Reset with rst_n=0 → all outputs 0 and state=0; hold 10 cycles and confirm no change.
- Soft-start: duty_wr with 50, then en=1 →
  - duty_act steps 8,16,24,32,40,48,50 on successive wraps;
  - state=RUN after the 50 step;
  - thereafter ctrl high 46 and ctrl_n high 46 cycles per 100-cycle period;
  - period_start once per 100 cycles.
- In RUN, duty_wr with 30 at cnt=20 → current period still 46 high; next period ctrl high 26, ctrl_n high 66.
- Fault:
  - fault=1 at cnt=10 → state=3 and both drives 0 next edge;
  - fault_clr while fault=1 → stays FAULT;
  - fault=0 then fault_clr → IDLE, then SOFT_START from duty_act=8 (en still 1).
- Boundaries:
  - duty=0 → ctrl never high, ctrl_n high 96;
  - duty=200 → clamped to 100, ctrl_n never high;
  - duty=3 → ctrl never high;
  - assert that ctrl&ctrl_n never occurs in any scenario.
- rst_n=0 asynchronously mid-RUN at cnt=40 → ctrl, ctrl_n, state and duty_act all 0 before the next clk edge.

Source files
------------

// File: rtl/pwm_ctrl_pkg.sv
// Shared types and constants for the PWM controller: FSM encoding and
// the minimum legal period derived from the dead time.
package pwm_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SOFT_START = 2'd1,
    RUN        = 2'd2,
    FAULT      = 2'd3
  } state_t;

  // Shortest period that still fits a dead band on both edges plus one on-cycle.
  function automatic int min_period(input int dead_time);
    return 2 * dead_time + 1;
  endfunction

  localparam int DEAD_TIME_DEFAULT  = 4;
  localparam int MIN_PERIOD_DEFAULT = min_period(DEAD_TIME_DEFAULT);

endpackage

// File: rtl/dead_time_gen.sv
// Break-before-make generator: turns the raw PWM level into a registered
// complementary drive pair with a dead band after every raw edge.
module dead_time_gen #(
  parameter int DEAD_TIME = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic active,
  input  logic sync,
  output logic ctrl,
  output logic ctrl_n
);

  localparam int DT_W = $clog2(DEAD_TIME + 1);
  localparam logic [DT_W-1:0] DT_LOAD = DT_W'(DEAD_TIME);
  localparam logic [DT_W-1:0] DT_ONE  = DT_W'(1);

  logic            raw_q;
  logic [DT_W-1:0] dt_q, dt_d;
  logic            ctrl_q, ctrl_d;
  logic            ctrl_n_q, ctrl_n_d;

  // sync restarts the dead band at each period boundary, so 0 % and 100 %
  // duty still get the same per-period blanking as ordinary edges.
  always_comb begin
    dt_d     = '0;
    ctrl_d   = 1'b0;
    ctrl_n_d = 1'b0;
    if (active) begin
      if ((raw != raw_q) || sync) begin
        dt_d = DT_LOAD;
      end else if (dt_q > DT_ONE) begin
        dt_d = dt_q - DT_ONE;
      end else begin
        ctrl_d   = raw;
        ctrl_n_d = ~raw;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_q    <= 1'b0;
      dt_q     <= '0;
      ctrl_q   <= 1'b0;
      ctrl_n_q <= 1'b0;
    end else begin
      raw_q    <= raw;
      dt_q     <= dt_d;
      ctrl_q   <= ctrl_d;
      ctrl_n_q <= ctrl_n_d;
    end
  end

  assign ctrl   = ctrl_q;
  assign ctrl_n = ctrl_n_q;

endmodule

// File: rtl/pwm_ctrl.sv
// PWM controller: idle / soft-start / run / latched-fault sequencing,
// period-synchronous duty and period updates, dead-time protected outputs.
module pwm_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH = 16,
  parameter int DEAD_TIME = DEAD_TIME_DEFAULT,
  parameter int SS_STEP   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [CNT_WIDTH-1:0] period,
  input  logic [CNT_WIDTH-1:0] duty,
  input  logic                 duty_wr,
  input  logic                 fault,
  input  logic                 fault_clr,
  output logic                 ctrl,
  output logic                 ctrl_n,
  output logic                 period_start,
  output logic [1:0]           state,
  output logic [CNT_WIDTH-1:0] duty_act
);

  localparam logic [CNT_WIDTH-1:0] MIN_PER = CNT_WIDTH'(min_period(DEAD_TIME));
  localparam logic [CNT_WIDTH:0]   STEP_X  = (CNT_WIDTH+1)'(SS_STEP);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] period_act_q, period_act_d;
  logic [CNT_WIDTH-1:0] duty_act_q, duty_act_d;
  logic [CNT_WIDTH-1:0] shadow_q, shadow_d;

  logic [CNT_WIDTH-1:0] period_clamped;
  logic [CNT_WIDTH:0]   tgt_x, ss_sum_x, ss_next_x;
  logic                 running_q, running_d, wrap, raw;

  assign period_clamped = (period < MIN_PER) ? MIN_PER : period;

  // Extra MSB keeps period_act+1 and duty_act+SS_STEP from wrapping.
  always_comb begin
    tgt_x     = {1'b0, period_act_q} + 1'b1;
    if ({1'b0, shadow_q} < tgt_x) tgt_x = {1'b0, shadow_q};
    ss_sum_x  = {1'b0, duty_act_q} + STEP_X;
    ss_next_x = (ss_sum_x < tgt_x) ? ss_sum_x : tgt_x;
  end

  assign running_q = (state_q == SOFT_START) || (state_q == RUN);
  assign wrap      = running_q && (cnt_q == period_act_q);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    period_act_d = period_act_q;
    duty_act_d   = duty_act_q;
    shadow_d     = duty_wr ? duty : shadow_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fault) begin
          state_d    = FAULT;
          duty_act_d = '0;
        end else if (en) begin
          state_d      = SOFT_START;
          period_act_d = period_clamped;
          duty_act_d   = '0;
        end
      end
      SOFT_START, RUN: begin
        if (fault) begin
          state_d    = FAULT;
          cnt_d      = '0;
          duty_act_d = '0;
        end else if (!en) begin
          state_d    = IDLE;
          cnt_d      = '0;
          duty_act_d = '0;
        end else if (wrap) begin
          cnt_d        = '0;
          period_act_d = period_clamped;
          if (state_q == SOFT_START) begin
            duty_act_d = ss_next_x[CNT_WIDTH-1:0];
            if (ss_next_x == tgt_x) state_d = RUN;
          end else begin
            duty_act_d = tgt_x[CNT_WIDTH-1:0];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FAULT: begin
        cnt_d      = '0;
        duty_act_d = '0;
        if (fault_clr && !fault) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      period_act_q <= '0;
      duty_act_q   <= '0;
      shadow_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      period_act_q <= period_act_d;
      duty_act_q   <= duty_act_d;
      shadow_q     <= shadow_d;
    end
  end

  // Drives are gated by both current and next state: they drop on the edge
  // that leaves RUN/SOFT_START and only start once the state has settled.
  assign running_d = (state_d == SOFT_START) || (state_d == RUN);
  assign raw       = ({1'b0, cnt_q} < {1'b0, duty_act_q});

  assign period_start = running_q && (cnt_q == '0);
  assign state        = state_q;
  assign duty_act     = duty_act_q;

  dead_time_gen #(
    .DEAD_TIME(DEAD_TIME)
  ) u_dead_time (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (raw),
    .active(running_q && running_d),
    .sync  (period_start),
    .ctrl  (ctrl),
    .ctrl_n(ctrl_n)
  );

endmodule

// File: tb/tb_pwm_ctrl.sv
// Self-checking bench for pwm_ctrl: expected values queued at stimulus time,
// popped and compared when the DUT reaches the matching period boundary.
module tb_pwm_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] period = 16'd99;
  logic [15:0] duty = 16'd0;
  logic        duty_wr = 1'b0;
  logic        fault = 1'b0;
  logic        fault_clr = 1'b0;
  logic        ctrl, ctrl_n, period_start;
  logic [1:0]  state;
  logic [15:0] duty_act;

  int errors = 0;
  int checks = 0;
  int overlap_cnt = 0;
  int exp_q[$];

  pwm_ctrl #(.CNT_WIDTH(16), .DEAD_TIME(4), .SS_STEP(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .period(period), .duty(duty),
    .duty_wr(duty_wr), .fault(fault), .fault_clr(fault_clr), .ctrl(ctrl),
    .ctrl_n(ctrl_n), .period_start(period_start), .state(state), .duty_act(duty_act)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ctrl === 1'b1 && ctrl_n === 1'b1) begin
      overlap_cnt++;
      $display("FAIL overlap: ctrl and ctrl_n both high at %0t", $time);
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_period_start();
    int n = 0;
    step();
    while (period_start !== 1'b1 && n < 400) begin
      step();
      n++;
    end
    if (period_start !== 1'b1) begin
      errors++;
      checks++;
      $display("FAIL ps_timeout: period_start=%b after %0d cycles, required 1", period_start, n);
    end
  endtask

  // Starts on the negedge of a cnt==0 cycle and ends on the next one.
  task automatic measure_window(input int wr_at, input logic [15:0] wr_val,
                                output int hc, output int hn, output int len);
    hc = 0; hn = 0; len = 0;
    do begin
      if (len == wr_at) begin
        duty    = wr_val;
        duty_wr = 1'b1;
      end else begin
        duty_wr = 1'b0;
      end
      hc += int'(ctrl);
      hn += int'(ctrl_n);
      len++;
      @(negedge clk);
    end while (period_start !== 1'b1 && len < 400);
    duty_wr = 1'b0;
  endtask

  task automatic write_duty(input logic [15:0] v);
    duty    = v;
    duty_wr = 1'b1;
    step();
    duty_wr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({ctrl, ctrl_n, period_start, state, duty_act} !== 21'd0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: ctrl=%b ctrl_n=%b ps=%b state=%0d duty_act=%0d, required all 0",
                 i, ctrl, ctrl_n, period_start, state, duty_act);
      end
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_soft_start();
    int v;
    write_duty(16'd50);
    for (int d = 8; d < 50; d += 8) exp_q.push_back(d);
    exp_q.push_back(50);
    en = 1'b1;
    wait_period_start();
    checks++;
    if (duty_act !== 16'd0 || state !== 2'd1) begin
      errors++;
      $display("FAIL ss_entry: duty_act=%0d state=%0d, required 0 and 1", duty_act, state);
    end
    while (exp_q.size() > 0) begin
      wait_period_start();
      v = exp_q.pop_front();
      checks++;
      if (duty_act !== 16'(v) || state !== ((v == 50) ? 2'd2 : 2'd1)) begin
        errors++;
        $display("FAIL ss_step: duty_act=%0d state=%0d, required %0d and %0d",
                 duty_act, state, v, (v == 50) ? 2 : 1);
      end
    end
  endtask

  task automatic test_steady_run();
    int hc, hn, len;
    exp_q.push_back(46); exp_q.push_back(46); exp_q.push_back(100);
    measure_window(-1, 16'd0, hc, hn, len);
    measure_window(-1, 16'd0, hc, hn, len);
    checks++;
    if (hc !== exp_q.pop_front()) begin errors++; $display("FAIL run_ctrl: high=%0d, required 46", hc); end
    checks++;
    if (hn !== exp_q.pop_front()) begin errors++; $display("FAIL run_ctrl_n: high=%0d, required 46", hn); end
    checks++;
    if (len !== exp_q.pop_front()) begin errors++; $display("FAIL run_period: cycles between period_start=%0d, required 100", len); end
  endtask

  task automatic test_midperiod_update();
    int hc, hn, len;
    exp_q.push_back(46); exp_q.push_back(26); exp_q.push_back(66);
    measure_window(20, 16'd30, hc, hn, len);
    checks++;
    if (hc !== exp_q.pop_front()) begin errors++; $display("FAIL upd_current: ctrl high=%0d, required 46", hc); end
    measure_window(-1, 16'd0, hc, hn, len);
    checks++;
    if (hc !== exp_q.pop_front()) begin errors++; $display("FAIL upd_next_ctrl: high=%0d, required 26", hc); end
    checks++;
    if (hn !== exp_q.pop_front()) begin errors++; $display("FAIL upd_next_ctrl_n: high=%0d, required 66", hn); end
  endtask

  task automatic test_fault();
    step(10);
    fault = 1'b1;
    step();
    checks++;
    if (state !== 2'd3 || ctrl !== 1'b0 || ctrl_n !== 1'b0 || duty_act !== 16'd0) begin
      errors++;
      $display("FAIL fault_entry: state=%0d ctrl=%b ctrl_n=%b duty_act=%0d, required 3 0 0 0",
               state, ctrl, ctrl_n, duty_act);
    end
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    checks++;
    if (state !== 2'd3) begin errors++; $display("FAIL fault_clr_blocked: state=%0d, required 3", state); end
    fault = 1'b0;
    step();
    checks++;
    if (state !== 2'd3) begin errors++; $display("FAIL fault_latched: state=%0d, required 3", state); end
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    checks++;
    if (state !== 2'd0) begin errors++; $display("FAIL fault_exit: state=%0d, required 0", state); end
    step();
    checks++;
    if (state !== 2'd1 || duty_act !== 16'd0) begin
      errors++;
      $display("FAIL restart: state=%0d duty_act=%0d, required 1 and 0", state, duty_act);
    end
    exp_q.push_back(8);
    wait_period_start();
    checks++;
    if (duty_act !== 16'(exp_q.pop_front())) begin errors++; $display("FAIL restart_step: duty_act=%0d, required 8", duty_act); end
  endtask

  task automatic test_boundary(input logic [15:0] v, input int e_duty, input int e_c, input int e_n);
    int hc, hn, len;
    exp_q.push_back(e_duty); exp_q.push_back(e_c); exp_q.push_back(e_n);
    write_duty(v);
    for (int i = 0; i < 5; i++) wait_period_start();
    measure_window(-1, 16'd0, hc, hn, len);
    checks++;
    if (duty_act !== 16'(exp_q.pop_front())) begin errors++; $display("FAIL bnd_duty(%0d): duty_act=%0d, required %0d", v, duty_act, e_duty); end
    measure_window(-1, 16'd0, hc, hn, len);
    checks++;
    if (hc !== exp_q.pop_front()) begin errors++; $display("FAIL bnd_ctrl(%0d): high=%0d, required %0d", v, hc, e_c); end
    checks++;
    if (hn !== exp_q.pop_front()) begin errors++; $display("FAIL bnd_ctrl_n(%0d): high=%0d, required %0d", v, hn, e_n); end
  endtask

  task automatic test_async_reset();
    write_duty(16'd50);
    for (int i = 0; i < 4; i++) wait_period_start();
    step(40);
    checks++;
    if (ctrl !== 1'b1) begin errors++; $display("FAIL pre_reset: ctrl=%b at cnt 40, required 1", ctrl); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (ctrl !== 1'b0 || ctrl_n !== 1'b0 || state !== 2'd0 || duty_act !== 16'd0) begin
      errors++;
      $display("FAIL async_reset: ctrl=%b ctrl_n=%b state=%0d duty_act=%0d, required all 0",
               ctrl, ctrl_n, state, duty_act);
    end
    en = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(2);
  endtask

  initial begin
    test_reset();
    test_soft_start();
    test_steady_run();
    test_midperiod_update();
    test_fault();
    test_boundary(16'd0,   0,   0, 96);
    test_boundary(16'd200, 100, 96, 0);
    test_boundary(16'd3,   3,   0, 93);
    test_async_reset();
    checks++;
    if (overlap_cnt !== 0) begin
      errors++;
      $display("FAIL no_overlap: overlapping cycles=%0d, required 0", overlap_cnt);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
